ame_grad_acc: RTL and testbench

Signed multiply-accumulate stage directly upstream of the AME number-approximation (MSB-position) stage. It sums products of gradient/residual sample pairs over one block and saturates the sum to the 48-bit signed range that stage consumes. It emits the sum on `comp_data_o` with a one-cycle `comp_init_o` pulse that drives the downstream `comp_init_i`.

---
 rtl/ame_grad_acc.sv | 144 ++++++++++++++
 tb/tb_ame_grad_acc.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ame_grad_acc.sv
// Signed multiply-accumulate over one block of sample pairs, saturated to a symmetric
// SAT_BITS range and presented to the MSB-position stage with a one-cycle init pulse.
module ame_grad_acc #(
  parameter int IN_DATA_BITS   = 16,
  parameter int COMP_DATA_BITS = 64,
  parameter int SAT_BITS       = 48,
  parameter int CNT_BITS       = 12
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             in_valid_i,
  input  logic                             in_last_i,
  input  logic signed [IN_DATA_BITS-1:0]   in_a_i,
  input  logic signed [IN_DATA_BITS-1:0]   in_b_i,
  input  logic                             abort_i,
  output logic                             comp_init_o,
  output logic        [COMP_DATA_BITS-1:0] comp_data_o,
  output logic        [CNT_BITS:0]         comp_cnt_o,
  output logic                             comp_sat_o,
  output logic                             comp_ovf_o
);
  localparam int PW = 2 * IN_DATA_BITS;
  localparam logic [CNT_BITS:0] CNT_LIMIT = {1'b0, {CNT_BITS{1'b1}}};
  localparam logic signed [COMP_DATA_BITS-1:0] SAT_MAX =
    {{(COMP_DATA_BITS-SAT_BITS+1){1'b0}}, {(SAT_BITS-1){1'b1}}};
  localparam logic signed [COMP_DATA_BITS-1:0] SAT_MIN = -SAT_MAX;

  if (PW + CNT_BITS >= COMP_DATA_BITS) begin : g_width_check
    $error("ame_grad_acc: accumulator too narrow for IN_DATA_BITS/CNT_BITS");
  end
  if (SAT_BITS > COMP_DATA_BITS) begin : g_sat_check
    $error("ame_grad_acc: SAT_BITS exceeds COMP_DATA_BITS");
  end

  typedef enum logic {IDLE, RUN} state_e;
  state_e state_q, state_d;

  // Stage 1: product register with block bookkeeping travelling alongside.
  logic signed [PW-1:0]             prod_q;
  logic                             p_valid_q, p_last_q, p_ovf_q;
  logic        [CNT_BITS:0]         p_cnt_q;
  logic        [CNT_BITS:0]         cnt_q, cnt_d;
  // Stage 2: accumulator and registered result.
  logic signed [COMP_DATA_BITS-1:0] acc_q, acc_d;
  logic signed [COMP_DATA_BITS-1:0] sum, clamped;
  logic                             clamp_hit;
  logic                             comp_init_q, comp_sat_q, comp_ovf_q;
  logic        [COMP_DATA_BITS-1:0] comp_data_q;
  logic        [CNT_BITS:0]         comp_cnt_q;

  logic accept, at_limit, take_last, finish;

  assign accept    = in_valid_i & ~abort_i;
  assign at_limit  = (cnt_q == CNT_LIMIT);
  assign take_last = in_last_i | at_limit;
  assign finish    = p_valid_q & p_last_q & ~abort_i;

  always_comb begin
    cnt_d = cnt_q;
    if (abort_i)     cnt_d = '0;
    else if (accept) cnt_d = take_last ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    sum       = acc_q + {{(COMP_DATA_BITS-PW){prod_q[PW-1]}}, prod_q};
    clamped   = sum;
    clamp_hit = 1'b0;
    // Negative limit is symmetric so the downstream |x| never overflows.
    if (sum > SAT_MAX) begin
      clamped   = SAT_MAX;
      clamp_hit = 1'b1;
    end else if (sum < SAT_MIN) begin
      clamped   = SAT_MIN;
      clamp_hit = 1'b1;
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (abort_i)        acc_d = '0;
    else if (p_valid_q) acc_d = p_last_q ? '0 : sum;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && !take_last) state_d = RUN;
      RUN: begin
        if (abort_i)                         state_d = IDLE;
        else if (accept && !take_last)       state_d = RUN;
        else if (p_valid_q && p_last_q)      state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prod_q    <= '0;
      p_valid_q <= 1'b0;
      p_last_q  <= 1'b0;
      p_ovf_q   <= 1'b0;
      p_cnt_q   <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      p_valid_q <= accept;
      if (accept) begin
        prod_q   <= PW'(in_a_i) * PW'(in_b_i);
        p_last_q <= take_last;
        p_ovf_q  <= at_limit;
        p_cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      comp_init_q <= 1'b0;
      comp_data_q <= '0;
      comp_cnt_q  <= '0;
      comp_sat_q  <= 1'b0;
      comp_ovf_q  <= 1'b0;
    end else begin
      comp_init_q <= finish;
      if (finish) begin
        comp_data_q <= clamped;
        comp_cnt_q  <= p_cnt_q;
        comp_sat_q  <= clamp_hit;
        comp_ovf_q  <= p_ovf_q;
      end
    end
  end

  assign comp_init_o = comp_init_q;
  assign comp_data_o = comp_data_q;
  assign comp_cnt_o  = comp_cnt_q;
  assign comp_sat_o  = comp_sat_q;
  assign comp_ovf_o  = comp_ovf_q;
endmodule

// File: tb/tb_ame_grad_acc.sv
// Directed bench for ame_grad_acc: one instance at default SAT_BITS, one at SAT_BITS=40,
// both driven by the same stimulus; a monitor pops hand-computed expectations on each pulse.
module tb_ame_grad_acc;
  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_last, abort;
  logic signed [15:0] in_a, in_b;

  logic        init_f, sat_f, ovf_f, init_s, sat_s, ovf_s;
  logic [63:0] data_f, data_s;
  logic [12:0] cnt_f, cnt_s;

  typedef struct packed {
    logic [63:0] data_f;
    logic [63:0] data_s;
    logic [12:0] cnt;
    logic        sat_s;
    logic        ovf;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  logic [31:0] cyc = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ame_grad_acc dut_full (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_last_i(in_last),
    .in_a_i(in_a), .in_b_i(in_b), .abort_i(abort),
    .comp_init_o(init_f), .comp_data_o(data_f), .comp_cnt_o(cnt_f),
    .comp_sat_o(sat_f), .comp_ovf_o(ovf_f)
  );

  ame_grad_acc #(.SAT_BITS(40)) dut_sat40 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_last_i(in_last),
    .in_a_i(in_a), .in_b_i(in_b), .abort_i(abort),
    .comp_init_o(init_s), .comp_data_o(data_s), .comp_cnt_o(cnt_s),
    .comp_sat_o(sat_s), .comp_ovf_o(ovf_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%h expected 0x%h (cyc %0d)", name, act, exp, cyc);
  endtask

  task automatic drive(input logic v, input logic l, input int a, input int b, input logic ab);
    in_valid = v; in_last = l; in_a = 16'(a); in_b = 16'(b); abort = ab;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  // Called in the cycle the finishing sample is driven; pulse is due 2 edges later.
  task automatic expect_blk(input longint df, input longint ds, input int c,
                            input logic ss, input logic ov);
    exp_t e;
    e.data_f = 64'(df);
    e.data_s = 64'(ds);
    e.cnt    = 13'(c);
    e.sat_s  = ss;
    e.ovf    = ov;
    e.cyc    = cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_init_f"}, 64'(init_f), 64'd0);
    check({tag, "_data_f"}, data_f, 64'd0);
    check({tag, "_cnt_f"},  64'(cnt_f), 64'd0);
    check({tag, "_sat_f"},  64'(sat_f), 64'd0);
    check({tag, "_ovf_f"},  64'(ovf_f), 64'd0);
    check({tag, "_init_s"}, 64'(init_s), 64'd0);
    check({tag, "_data_s"}, data_s, 64'd0);
    check({tag, "_cnt_s"},  64'(cnt_s), 64'd0);
    check({tag, "_sat_s"},  64'(sat_s), 64'd0);
    check({tag, "_ovf_s"},  64'(ovf_s), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && (init_f || init_s)) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pulse: got init_f=%0b init_s=%0b expected no pulse (cyc %0d)",
                 init_f, init_s, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", 64'(cyc), 64'(e.cyc));
        check("init_f", 64'(init_f), 64'd1);
        check("init_s", 64'(init_s), 64'd1);
        check("data_f", data_f, e.data_f);
        check("cnt_f",  64'(cnt_f), 64'(e.cnt));
        check("sat_f",  64'(sat_f), 64'd0);
        check("ovf_f",  64'(ovf_f), 64'(e.ovf));
        check("data_s", data_s, e.data_s);
        check("cnt_s",  64'(cnt_s), 64'(e.cnt));
        check("sat_s",  64'(sat_s), 64'(e.sat_s));
        check("ovf_s",  64'(ovf_s), 64'(e.ovf));
      end
    end
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; abort = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single block: 15 - 14 - 100 + 0 = -99
    drive(1'b1, 1'b0, 3, 5, 1'b0);
    drive(1'b1, 1'b0, -2, 7, 1'b0);
    drive(1'b1, 1'b0, 100, -1, 1'b0);
    expect_blk(-64'sd99, -64'sd99, 4, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 0, 9, 1'b0);
    idle(4);

    // 4096 x 2^30 = 2^42; the 4096th sample also hits the count limit
    for (int i = 0; i < 4095; i++) drive(1'b1, 1'b0, -32768, -32768, 1'b0);
    expect_blk(64'h0000_0400_0000_0000, 64'h0000_007F_FFFF_FFFF, 4096, 1'b1, 1'b1);
    drive(1'b1, 1'b1, -32768, -32768, 1'b0);
    idle(4);

    // 4096 x -(2^30 - 2^15) = -(2^42 - 2^27)
    for (int i = 0; i < 4095; i++) drive(1'b1, 1'b0, -32768, 32767, 1'b0);
    expect_blk(64'hFFFF_FC00_0800_0000, 64'hFFFF_FF80_0000_0001, 4096, 1'b1, 1'b1);
    drive(1'b1, 1'b1, -32768, 32767, 1'b0);

    // Count limit with in_last never asserted, then a fresh one-sample block
    for (int i = 0; i < 4095; i++) drive(1'b1, 1'b0, 1, 1, 1'b0);
    expect_blk(64'd4096, 64'd4096, 4096, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1, 1, 1'b0);
    expect_blk(64'd1, 64'd1, 1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1, 1, 1'b0);
    idle(4);

    // Back-to-back blocks {(2,2)} and {(3,3),(4,4)}
    expect_blk(64'd4, 64'd4, 1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2, 2, 1'b0);
    drive(1'b1, 1'b0, 3, 3, 1'b0);
    expect_blk(64'd25, 64'd25, 2, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4, 4, 1'b0);
    idle(4);

    // Abort together with a valid sample: block discarded
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 10, 10, 1'b0);
    drive(1'b1, 1'b0, 10, 10, 1'b1);
    idle(4);
    expect_blk(64'd1, 64'd1, 1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1, 1, 1'b0);
    idle(4);

    // Abort in the cycle after a last sample: pulse suppressed, outputs hold
    drive(1'b1, 1'b1, 7, 7, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 1'b1);
    idle(4);
    check("hold_data_f", data_f, 64'd1);
    check("hold_cnt_f",  64'(cnt_f), 64'd1);
    check("hold_data_s", data_s, 64'd1);

    // Asynchronous reset in the middle of a block
    drive(1'b1, 1'b0, 9, 9, 1'b0);
    drive(1'b1, 1'b0, 9, 9, 1'b0);
    #3 rst_n = 1'b0;
    #1 check_outputs_zero("async_rst");
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    expect_blk(-64'sd25, -64'sd25, 1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 5, -5, 1'b0);
    idle(6);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
